// File: rtl/elevator_pkg.sv
// Shared state encoding and default sizing for the SCAN elevator scheduler.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam int unsigned N_FLOORS      = 5;
    localparam int unsigned FLOOR_W       = 3;
    localparam int unsigned TRAVEL_CYCLES = 2;
    localparam int unsigned DOOR_CYCLES   = 4;

endpackage

// File: rtl/elevator_call_scan.sv
// Combinational view of the pending-call vector relative to one floor:
// calls above, below, at the floor, and ahead/behind in a given direction.
module elevator_call_scan #(
    parameter int unsigned N_FLOORS = 5,
    parameter int unsigned FLOOR_W  = 3
) (
    input  logic [N_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]  floor_i,
    input  logic                dir_up_i,
    output logic                up_pend_o,
    output logic                dn_pend_o,
    output logic                here_o,
    output logic                ahead_o,
    output logic                behind_o
);

    // Classify every pending call as above, below or at the reference floor.
    always_comb begin
        up_pend_o = 1'b0;
        dn_pend_o = 1'b0;
        here_o    = 1'b0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            if (pending_i[i]) begin
                if (FLOOR_W'(i) > floor_i) up_pend_o = 1'b1;
                if (FLOOR_W'(i) < floor_i) dn_pend_o = 1'b1;
                if (FLOOR_W'(i) == floor_i) here_o   = 1'b1;
            end
        end
        ahead_o  = dir_up_i ? up_pend_o : dn_pend_o;
        behind_o = dir_up_i ? dn_pend_o : up_pend_o;
    end

endmodule

// File: rtl/elevator_scan_scheduler.sv
// Single-car SCAN scheduler: latches floor calls, keeps travelling in one
// direction while calls remain ahead, reverses otherwise, and times the
// per-floor travel and the door dwell.
module elevator_scan_scheduler #(
    parameter int unsigned N_FLOORS      = elevator_pkg::N_FLOORS,
    parameter int unsigned FLOOR_W       = elevator_pkg::FLOOR_W,
    parameter int unsigned TRAVEL_CYCLES = elevator_pkg::TRAVEL_CYCLES,
    parameter int unsigned DOOR_CYCLES   = elevator_pkg::DOOR_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] call_req,
    input  logic                door_hold,
    output logic [FLOOR_W-1:0]  floor_pos,
    output logic                dir_up,
    output logic                moving,
    output logic                door_open,
    output logic                arrive,
    output logic [N_FLOORS-1:0] pending
);

    import elevator_pkg::*;

    localparam int unsigned TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int unsigned DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

    state_t              state_q;
    logic [FLOOR_W-1:0]  floor_q;
    logic                dir_q;
    logic                moving_q;
    logic                door_q;
    logic                arrive_q;
    logic [N_FLOORS-1:0] pending_q, pending_d;
    logic [TW-1:0]       trav_cnt_q;
    logic [DW-1:0]       door_cnt_q;

    logic [FLOOR_W-1:0]  nf;
    logic [N_FLOORS-1:0] floor_oh, nf_oh;
    logic                cur_up, cur_dn, cur_here, cur_ahead, cur_behind;
    logic                nf_up, nf_dn, nf_here_p, nf_ahead, nf_behind;
    logic                nf_stop, step, reopen;
    logic [N_FLOORS-1:0] set_mask, clr_mask;
    logic                unused_nf;

    assign nf   = dir_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
    assign step = (state_q == MOVE) && (trav_cnt_q == '0);

    elevator_call_scan #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_scan_cur (
        .pending_i (pending_q),
        .floor_i   (floor_q),
        .dir_up_i  (dir_q),
        .up_pend_o (cur_up),
        .dn_pend_o (cur_dn),
        .here_o    (cur_here),
        .ahead_o   (cur_ahead),
        .behind_o  (cur_behind)
    );

    elevator_call_scan #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_scan_nf (
        .pending_i (pending_q),
        .floor_i   (nf),
        .dir_up_i  (dir_q),
        .up_pend_o (nf_up),
        .dn_pend_o (nf_dn),
        .here_o    (nf_here_p),
        .ahead_o   (nf_ahead),
        .behind_o  (nf_behind)
    );

    assign unused_nf = ^{nf_up, nf_dn, nf_behind};

    // One-hot decode of the current and next floor for masking calls.
    always_comb begin
        floor_oh = '0;
        nf_oh    = '0;
        for (int unsigned i = 0; i < N_FLOORS; i++) begin
            floor_oh[i] = (FLOOR_W'(i) == floor_q);
            nf_oh[i]    = (FLOOR_W'(i) == nf);
        end
    end

    // Call latching: set wins over clear, except a call for the floor whose
    // door is open, which only re-opens the door and is never latched.
    always_comb begin
        nf_stop  = nf_here_p || ((call_req & nf_oh) != '0);
        reopen   = (state_q == DOOR) && ((call_req & floor_oh) != '0);
        set_mask = call_req;
        clr_mask = '0;
        if (state_q == DOOR) set_mask = call_req & ~floor_oh;
        if (state_q == IDLE && cur_here) clr_mask = floor_oh;
        if (step && nf_stop) clr_mask = nf_oh;
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    // Scheduler FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            moving_q   <= 1'b0;
            door_q     <= 1'b0;
            arrive_q   <= 1'b0;
            pending_q  <= '0;
            trav_cnt_q <= '0;
            door_cnt_q <= '0;
        end else begin
            pending_q <= pending_d;
            arrive_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cur_here) begin
                        state_q    <= DOOR;
                        door_q     <= 1'b1;
                        arrive_q   <= 1'b1;
                        door_cnt_q <= DW'(DOOR_CYCLES - 1);
                    end else if (cur_up && (dir_q || !cur_dn)) begin
                        state_q    <= MOVE;
                        moving_q   <= 1'b1;
                        dir_q      <= 1'b1;
                        trav_cnt_q <= TW'(TRAVEL_CYCLES - 1);
                    end else if (cur_dn) begin
                        state_q    <= MOVE;
                        moving_q   <= 1'b1;
                        dir_q      <= 1'b0;
                        trav_cnt_q <= TW'(TRAVEL_CYCLES - 1);
                    end
                end
                MOVE: begin
                    if (trav_cnt_q != '0) begin
                        trav_cnt_q <= trav_cnt_q - TW'(1);
                    end else begin
                        floor_q <= nf;
                        if (nf_stop) begin
                            state_q    <= DOOR;
                            moving_q   <= 1'b0;
                            door_q     <= 1'b1;
                            arrive_q   <= 1'b1;
                            door_cnt_q <= DW'(DOOR_CYCLES - 1);
                        end else if (nf_ahead) begin
                            trav_cnt_q <= TW'(TRAVEL_CYCLES - 1);
                        end else begin
                            state_q  <= IDLE;
                            moving_q <= 1'b0;
                        end
                    end
                end
                DOOR: begin
                    if (door_hold || reopen) begin
                        door_cnt_q <= DW'(DOOR_CYCLES - 1);
                    end else if (door_cnt_q != '0) begin
                        door_cnt_q <= door_cnt_q - DW'(1);
                    end else begin
                        door_q <= 1'b0;
                        if (cur_ahead || cur_behind) begin
                            state_q    <= MOVE;
                            moving_q   <= 1'b1;
                            dir_q      <= cur_ahead ? dir_q : ~dir_q;
                            trav_cnt_q <= TW'(TRAVEL_CYCLES - 1);
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    moving_q <= 1'b0;
                    door_q   <= 1'b0;
                end
            endcase
        end
    end

    assign floor_pos = floor_q;
    assign dir_up    = dir_q;
    assign moving    = moving_q;
    assign door_open = door_q;
    assign arrive    = arrive_q;
    assign pending   = pending_q;

    // The car must never step past the top or bottom floor.
    assert property (@(posedge clk) disable iff (reset)
        step |-> (dir_q ? (floor_q != FLOOR_W'(N_FLOORS - 1)) : (floor_q != '0)));

endmodule

// File: tb/tb_elevator_scan_scheduler.sv
// Directed bench for the SCAN elevator scheduler with hand-computed expectations.
module tb_elevator_scan_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] call_req;
    logic       door_hold;
    logic [2:0] floor_pos;
    logic       dir_up, moving, door_open, arrive;
    logic [4:0] pending;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    elevator_scan_scheduler #(
        .N_FLOORS(5), .FLOOR_W(3), .TRAVEL_CYCLES(2), .DOOR_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .call_req  (call_req),
        .door_hold (door_hold),
        .floor_pos (floor_pos),
        .dir_up    (dir_up),
        .moving    (moving),
        .door_open (door_open),
        .arrive    (arrive),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {floor_pos, moving, door_open, arrive} after each edge of a 0->2 trip
    logic [5:0] trip_exp [10];
    logic [2:0] stop_floor [4];
    int         stop_tick  [4];
    int         n_stops;

    task automatic record_stop(input int t);
        if (arrive && n_stops < 4) begin
            stop_floor[n_stops] = floor_pos;
            stop_tick[n_stops]  = t;
            n_stops++;
        end
    endtask

    initial begin
        trip_exp = '{6'b000_000, 6'b000_100, 6'b000_100, 6'b001_100, 6'b001_100,
                     6'b010_011, 6'b010_010, 6'b010_010, 6'b010_010, 6'b010_000};
        reset     = 1'b1;
        call_req  = '0;
        door_hold = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset values, then a quiet idle stretch.
        check_eq("reset_state", {floor_pos, dir_up, moving, door_open, arrive, pending},
                 {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("idle_hold", {floor_pos, dir_up, moving, door_open, pending},
                     {3'd0, 1'b1, 1'b0, 1'b0, 5'd0});
        end

        // Call floor 2 from floor 0: two floors of travel, arrive, 4-cycle dwell.
        call_req = 5'b00100;
        for (int t = 0; t < 10; t++) begin
            tick();
            call_req = '0;
            check_eq($sformatf("trip_t%0d", t), {floor_pos, moving, door_open, arrive}, trip_exp[t]);
        end
        check_eq("trip_pending", pending, 5'b00000);

        // Door re-open: call for the current floor during the dwell.
        call_req = 5'b00100;
        tick();
        call_req = '0;
        check_eq("reopen_latch", pending, 5'b00100);
        tick();
        check_eq("reopen_open", {door_open, arrive, pending}, {1'b1, 1'b1, 5'd0});
        tick();
        tick();
        call_req = 5'b00100;
        tick();
        call_req = '0;
        check_eq("reopen_nolatch", {door_open, pending}, {1'b1, 5'd0});
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("reopen_dwell", door_open, 1'b1);
        end
        tick();
        check_eq("reopen_close", {door_open, moving}, {1'b0, 1'b0});

        // Door hold for 6 cycles, then 4 more cycles of dwell.
        call_req = 5'b00100;
        tick();
        call_req = '0;
        tick();
        check_eq("hold_open", door_open, 1'b1);
        door_hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("hold_held", door_open, 1'b1);
        end
        door_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_dwell", door_open, 1'b1);
        end
        tick();
        check_eq("hold_close", door_open, 1'b0);

        // SCAN reversal: heading up to 3, a call for 0 arrives at floor 1.
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        n_stops = 0;
        for (int t = 0; t < 30; t++) begin
            call_req = (t == 0) ? 5'b01000 : (t == 4) ? 5'b00001 : 5'b00000;
            tick();
            record_stop(t);
            if (t == 3) check_eq("scan_at1", {floor_pos, moving, dir_up}, {3'd1, 1'b1, 1'b1});
            if (t == 11) check_eq("scan_reverse", {moving, dir_up}, {1'b1, 1'b0});
        end
        call_req = '0;
        check_eq("scan_nstops", n_stops, 2);
        check_eq("scan_stop0", {stop_floor[0], 8'(stop_tick[0])}, {3'd3, 8'd7});
        check_eq("scan_stop1", {stop_floor[1], 8'(stop_tick[1])}, {3'd0, 8'd17});
        check_eq("scan_end", {floor_pos, dir_up, moving, door_open, pending},
                 {3'd0, 1'b0, 1'b0, 1'b0, 5'd0});

        // Call for floor 3 on the very cycle the car reaches it on the way to 4.
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        n_stops = 0;
        for (int t = 0; t < 40; t++) begin
            call_req = (t == 0) ? 5'b10000 : (t == 7) ? 5'b01000 : 5'b00000;
            tick();
            record_stop(t);
        end
        call_req = '0;
        check_eq("late_stop0", {stop_floor[0], 8'(stop_tick[0])}, {3'd3, 8'd7});
        check_eq("late_stop1", {stop_floor[1], 8'(stop_tick[1])}, {3'd4, 8'd13});
        check_eq("late_settle", {moving, door_open}, {1'b0, 1'b0});

        // Reset mid-travel between floors 1 and 2 with calls {2,4} pending.
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        call_req = 5'b10100;
        tick();
        call_req = '0;
        tick();
        tick();
        tick();
        check_eq("abort_pre", {floor_pos, moving, pending}, {3'd1, 1'b1, 5'b10100});
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_state", {floor_pos, dir_up, moving, door_open, arrive, pending},
                 {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0});
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("abort_still", {floor_pos, moving, door_open}, {3'd0, 1'b0, 1'b0});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
